// File: rtl/alu_issue_ctrl.sv
// Issue controller for the 8-bit combinational ALU: register-file operand fetch, timed issue,
// result/flag capture and writeback. Optional macro ALU_ISSUE_STICKY_OF_EN makes flags_q[7] sticky.
module alu_issue_ctrl #(
    parameter int unsigned ADDR_W      = 3,
    parameter int unsigned ALU_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [7:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_rd,
    input  logic [ADDR_W-1:0] cmd_rs,
    input  logic [ADDR_W-1:0] cmd_rt,
    input  logic              cmd_imm_en,
    input  logic [7:0]        cmd_imm,
    output logic [7:0]        alu_a,
    output logic [7:0]        alu_b,
    output logic [7:0]        alu_sel,
    input  logic [7:0]        alu_x,
    input  logic [7:0]        alu_flags,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [7:0]        rsp_result,
    output logic [7:0]        rsp_flags,
    output logic              rsp_err,
    output logic [7:0]        flags_q,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [7:0]        dbg_data
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

    state_e             r_state;
    state_e             w_state_nxt;
    logic [7:0]         r_rf [DEPTH];
    logic [7:0]         r_a;
    logic [7:0]         r_b;
    logic [7:0]         r_op;
    logic [ADDR_W-1:0]  r_rd;
    logic [CNT_W-1:0]   r_cnt;
    logic [7:0]         r_rsp_result;
    logic [7:0]         r_rsp_flags;
    logic               r_rsp_err;
    logic [7:0]         r_flags;

    logic               w_accept;
    logic               w_capture;
    logic               w_err;
    logic [7:0]         w_b;
    logic [7:0]         w_flags_cap;

    assign w_accept  = (r_state == StIdle) && cmd_valid;
    assign w_capture = (r_state == StIssue) && (r_cnt == '0);
    assign w_b       = cmd_imm_en ? cmd_imm : r_rf[cmd_rt];
    // Division and modulo by zero are refused before the ALU ever sees them.
    assign w_err     = (cmd_op == 8'h00) || (cmd_op > 8'h0F) ||
                       (((cmd_op == 8'h04) || (cmd_op == 8'h05)) && (w_b == 8'h00));

`ifdef ALU_ISSUE_STICKY_OF_EN
    assign w_flags_cap = {r_flags[7] | alu_flags[6], alu_flags[6:0]};
`else
    assign w_flags_cap = alu_flags;
`endif

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle:  if (cmd_valid) w_state_nxt = w_err ? StResp : StIssue;
            StIssue: if (r_cnt == '0) w_state_nxt = StResp;
            StResp:  if (rsp_ready) w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_a          <= 8'h00;
            r_b          <= 8'h00;
            r_op         <= 8'h00;
            r_rd         <= '0;
            r_cnt        <= '0;
            r_rsp_result <= 8'h00;
            r_rsp_flags  <= 8'h00;
            r_rsp_err    <= 1'b0;
            r_flags      <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_a   <= r_rf[cmd_rs];
                r_b   <= w_b;
                r_op  <= cmd_op;
                r_rd  <= cmd_rd;
                r_cnt <= CNT_W'(ALU_LATENCY - 1);
                if (w_err) begin
                    r_rsp_err    <= 1'b1;
                    r_rsp_result <= 8'h00;
                    r_rsp_flags  <= r_flags;
                end
            end else if (r_state == StIssue) begin
                if (r_cnt == '0) begin
                    r_rsp_err    <= 1'b0;
                    r_rsp_result <= alu_x;
                    r_rsp_flags  <= w_flags_cap;
                    r_flags      <= w_flags_cap;
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end
        end
    end

    // Compare (0x0F) only updates flags; every other op writes back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_rf[i] <= 8'h00;
            end
        end else if (w_capture && (r_op != 8'h0F)) begin
            r_rf[r_rd] <= alu_x;
        end
    end

    assign cmd_ready  = (r_state == StIdle);
    assign rsp_valid  = (r_state == StResp);
    assign alu_a      = (r_state == StIssue) ? r_a  : 8'h00;
    assign alu_b      = (r_state == StIssue) ? r_b  : 8'h00;
    assign alu_sel    = (r_state == StIssue) ? r_op : 8'h00;
    assign rsp_result = r_rsp_result;
    assign rsp_flags  = r_rsp_flags;
    assign rsp_err    = r_rsp_err;
    assign flags_q    = r_flags;
    assign dbg_data   = r_rf[dbg_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: two instances (latency 1 and 3) driven by directed and random
// commands, with a behavioural ALU and a reference register-file/flags model.
module tb_alu_issue_ctrl;

    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    logic       clk;
    logic       rst_n      [2];
    logic       cmd_valid  [2];
    logic       cmd_ready  [2];
    logic [7:0] cmd_op     [2];
    logic [2:0] cmd_rd     [2];
    logic [2:0] cmd_rs     [2];
    logic [2:0] cmd_rt     [2];
    logic       cmd_imm_en [2];
    logic [7:0] cmd_imm    [2];
    logic [7:0] alu_a      [2];
    logic [7:0] alu_b      [2];
    logic [7:0] alu_sel    [2];
    logic [7:0] alu_x      [2];
    logic [7:0] alu_flags  [2];
    logic       rsp_valid  [2];
    logic       rsp_ready  [2];
    logic [7:0] rsp_result [2];
    logic [7:0] rsp_flags  [2];
    logic       rsp_err    [2];
    logic [7:0] flags_q    [2];
    logic [2:0] dbg_addr   [2];
    logic [7:0] dbg_data   [2];

    logic [7:0] mdl_rf    [2][8];
    logic [7:0] mdl_flags [2];
    int n_assert = 0;
    int n_fail   = 0;

    // Behavioural ALU: returns {flags, x}; flags bits 0=Z 1=C 2=S 3=P 6=O, bit 7 always 0.
    function automatic logic [15:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                              input logic [7:0] sel);
        logic [8:0] w;
        logic [7:0] x;
        logic o, z;
        w = 9'h000;
        o = 1'b0;
        case (sel)
            8'h01: begin w = {1'b0, a} + {1'b0, b}; o = (a[7] == b[7]) && (w[7] != a[7]); end
            8'h02: begin w = {1'b0, a} - {1'b0, b}; o = (a[7] != b[7]) && (w[7] != a[7]); end
            8'h03: w = {1'b0, 8'(a * b)};
            8'h04: w = (b != 0) ? {1'b0, a / b} : 9'h000;
            8'h05: w = (b != 0) ? {1'b0, a % b} : 9'h000;
            8'h06: w = {1'b0, a & b};
            8'h07: w = {1'b0, a | b};
            8'h08: w = {1'b0, a ^ b};
            8'h09: w = {1'b0, ~a};
            8'h0A: w = {a, 1'b0};
            8'h0B: w = {1'b0, 1'b0, a[7:1]};
            8'h0C: w = {1'b0, a} + 9'h001;
            8'h0D: w = {1'b0, a} - 9'h001;
            8'h0E: w = {1'b0, b};
            8'h0F: w = (a == b) ? 9'h001 : 9'h000;
            default: w = 9'h000;
        endcase
        x = w[7:0];
        z = (sel == 8'h0F) ? (a == b) : (x == 8'h00);
        return {1'b0, o, 2'b00, ~^x, x[7], w[8], z, x};
    endfunction

    assign {alu_flags[0], alu_x[0]} = alu_model(alu_a[0], alu_b[0], alu_sel[0]);
    assign {alu_flags[1], alu_x[1]} = alu_model(alu_a[1], alu_b[1], alu_sel[1]);

    alu_issue_ctrl #(.ADDR_W(3), .ALU_LATENCY(LAT0)) u_dut0 (
        .clk(clk), .rst_n(rst_n[0]), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
        .cmd_op(cmd_op[0]), .cmd_rd(cmd_rd[0]), .cmd_rs(cmd_rs[0]), .cmd_rt(cmd_rt[0]),
        .cmd_imm_en(cmd_imm_en[0]), .cmd_imm(cmd_imm[0]), .alu_a(alu_a[0]), .alu_b(alu_b[0]),
        .alu_sel(alu_sel[0]), .alu_x(alu_x[0]), .alu_flags(alu_flags[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_result(rsp_result[0]),
        .rsp_flags(rsp_flags[0]), .rsp_err(rsp_err[0]), .flags_q(flags_q[0]),
        .dbg_addr(dbg_addr[0]), .dbg_data(dbg_data[0])
    );

    alu_issue_ctrl #(.ADDR_W(3), .ALU_LATENCY(LAT1)) u_dut1 (
        .clk(clk), .rst_n(rst_n[1]), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
        .cmd_op(cmd_op[1]), .cmd_rd(cmd_rd[1]), .cmd_rs(cmd_rs[1]), .cmd_rt(cmd_rt[1]),
        .cmd_imm_en(cmd_imm_en[1]), .cmd_imm(cmd_imm[1]), .alu_a(alu_a[1]), .alu_b(alu_b[1]),
        .alu_sel(alu_sel[1]), .alu_x(alu_x[1]), .alu_flags(alu_flags[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_result(rsp_result[1]),
        .rsp_flags(rsp_flags[1]), .rsp_err(rsp_err[1]), .flags_q(flags_q[1]),
        .dbg_addr(dbg_addr[1]), .dbg_data(dbg_data[1])
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    function automatic int lat_of(input int d);
        return (d == 0) ? LAT0 : LAT1;
    endfunction

    task automatic mdl_reset(input int d);
        for (int i = 0; i < 8; i++) mdl_rf[d][i] = 8'h00;
        mdl_flags[d] = 8'h00;
    endtask

    task automatic dbg_sweep(input int d, input string tag);
        for (int i = 0; i < 8; i++) begin
            dbg_addr[d] = 3'(i);
            #1;
            chk($sformatf("%s_reg%0d", tag, i), dbg_data[d], mdl_rf[d][i]);
        end
    endtask

    task automatic reset_check(input int d);
        chk("rst_rsp_valid", {7'b0, rsp_valid[d]}, 8'h00);
        chk("rst_rsp_result", rsp_result[d], 8'h00);
        chk("rst_rsp_flags", rsp_flags[d], 8'h00);
        chk("rst_rsp_err", {7'b0, rsp_err[d]}, 8'h00);
        chk("rst_flags_q", flags_q[d], 8'h00);
        chk("rst_alu_a", alu_a[d], 8'h00);
        chk("rst_alu_b", alu_b[d], 8'h00);
        chk("rst_alu_sel", alu_sel[d], 8'h00);
        dbg_sweep(d, "rst");
    endtask

    // Issue one command starting just after a falling edge and complete its response.
    task automatic do_cmd(input int d, input logic [7:0] op, input int rd, input int rs,
                          input int rt, input logic ie, input logic [7:0] imm, input int hold);
        logic [7:0] a, b, ex_res, ex_fl, res0, fl0;
        logic [15:0] r;
        logic ex_err;
        int k;
        a = mdl_rf[d][rs];
        b = ie ? imm : mdl_rf[d][rt];
        ex_err = (op == 8'h00) || (op > 8'h0F) || (((op == 8'h04) || (op == 8'h05)) && b == 0);
        if (ex_err) begin
            ex_res = 8'h00;
            ex_fl  = mdl_flags[d];
        end else begin
            r = alu_model(a, b, op);
            ex_res = r[7:0];
            ex_fl  = r[15:8];
`ifdef ALU_ISSUE_STICKY_OF_EN
            ex_fl[7] = mdl_flags[d][7] | r[14];
`endif
            mdl_flags[d] = ex_fl;
            if (op != 8'h0F) mdl_rf[d][rd] = ex_res;
        end
        chk("cmd_ready_idle", {7'b0, cmd_ready[d]}, 8'h01);
        cmd_op[d] = op; cmd_rd[d] = 3'(rd); cmd_rs[d] = 3'(rs); cmd_rt[d] = 3'(rt);
        cmd_imm_en[d] = ie; cmd_imm[d] = imm; cmd_valid[d] = 1'b1; rsp_ready[d] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cmd_valid[d] = 1'b0;
        k = 0;
        while (rsp_valid[d] !== 1'b1 && k < lat_of(d) + 4) begin
            if (!ex_err) begin
                chk("issue_sel", alu_sel[d], op);
                chk("issue_a", alu_a[d], a);
                chk("issue_b", alu_b[d], b);
            end
            chk("cmd_ready_busy", {7'b0, cmd_ready[d]}, 8'h00);
            @(posedge clk);
            @(negedge clk);
            k++;
        end
        chk("latency", 8'(k), ex_err ? 8'h00 : 8'(lat_of(d)));
        chk("rsp_result", rsp_result[d], ex_res);
        chk("rsp_flags", rsp_flags[d], ex_fl);
        chk("rsp_err", {7'b0, rsp_err[d]}, {7'b0, ex_err});
        chk("flags_q", flags_q[d], mdl_flags[d]);
        chk("resp_alu_sel", alu_sel[d], 8'h00);
        res0 = rsp_result[d];
        fl0  = rsp_flags[d];
        for (int i = 0; i < hold; i++) begin
            // A competing command must not be taken while the response waits.
            cmd_op[d] = 8'h01; cmd_rd[d] = 3'd7; cmd_rs[d] = 3'd1; cmd_imm_en[d] = 1'b1;
            cmd_imm[d] = 8'h11; cmd_valid[d] = 1'b1;
            @(posedge clk);
            @(negedge clk);
            chk("hold_valid", {7'b0, rsp_valid[d]}, 8'h01);
            chk("hold_ready", {7'b0, cmd_ready[d]}, 8'h00);
            chk("hold_result", rsp_result[d], res0);
            chk("hold_flags", rsp_flags[d], fl0);
        end
        cmd_valid[d] = 1'b0;
        rsp_ready[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready[d] = 1'b0;
        chk("rsp_valid_drop", {7'b0, rsp_valid[d]}, 8'h00);
        dbg_addr[d] = 3'(rd);
        #1;
        chk("dbg_rd", dbg_data[d], mdl_rf[d][rd]);
    endtask

    task automatic rand_cmd(input int d);
        int r;
        logic [7:0] op, imm;
        r = $urandom_range(0, 19);
        op = (r <= 15) ? 8'(r) : 8'($urandom_range(16, 255));
        imm = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
        do_cmd(d, op, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
               1'($urandom_range(0, 1)), imm, $urandom_range(0, 2));
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; cmd_valid[d] = 1'b0; cmd_op[d] = 8'h00; cmd_rd[d] = 3'd0;
            cmd_rs[d] = 3'd0; cmd_rt[d] = 3'd0; cmd_imm_en[d] = 1'b0; cmd_imm[d] = 8'h00;
            rsp_ready[d] = 1'b0; dbg_addr[d] = 3'd0;
            mdl_reset(d);
        end
        #25;
        reset_check(0);
        reset_check(1);
        @(negedge clk);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        @(negedge clk);
        chk("ready_after_rst0", {7'b0, cmd_ready[0]}, 8'h01);
        chk("ready_after_rst1", {7'b0, cmd_ready[1]}, 8'h01);

        // Load 0x7F and 0x01, then overflowing add into reg3.
        do_cmd(0, 8'h01, 1, 0, 0, 1'b1, 8'h7F, 0);
        do_cmd(0, 8'h01, 2, 0, 0, 1'b1, 8'h01, 0);
        do_cmd(0, 8'h01, 3, 1, 2, 1'b0, 8'h00, 0);
        chk("add_ovf_result", dbg_data[0], 8'h80);
        chk("add_ovf_O_S", flags_q[0] & 8'h44, 8'h44);

        // Division by an immediate zero is refused.
        do_cmd(0, 8'h01, 4, 0, 0, 1'b1, 8'h09, 0);
        do_cmd(0, 8'h04, 4, 4, 0, 1'b1, 8'h00, 0);
        chk("div0_dest", dbg_data[0], 8'h09);

        // Compare leaves the destination alone.
        do_cmd(0, 8'h01, 6, 0, 0, 1'b1, 8'h05, 0);
        do_cmd(0, 8'h0F, 6, 6, 0, 1'b1, 8'h05, 0);
        chk("cmp_dest", dbg_data[0], 8'h05);
        chk("cmp_Z", flags_q[0] & 8'h01, 8'h01);

        // Backpressure on the response.
        do_cmd(0, 8'h02, 5, 1, 2, 1'b0, 8'h00, 5);

        // Illegal selectors.
        do_cmd(0, 8'h10, 5, 1, 2, 1'b0, 8'h00, 0);
        do_cmd(0, 8'h00, 5, 1, 2, 1'b0, 8'h00, 1);

        // Small add after the overflow; bit 7 reflects the sticky option.
        do_cmd(0, 8'h01, 7, 2, 2, 1'b0, 8'h00, 0);

        for (int i = 0; i < 40; i++) rand_cmd(0);
        dbg_sweep(0, "final0");

        // Latency-3 instance: a few commands, then reset during the second issue cycle.
        do_cmd(1, 8'h01, 1, 0, 0, 1'b1, 8'h33, 0);
        do_cmd(1, 8'h0C, 2, 1, 0, 1'b1, 8'h00, 2);
        for (int i = 0; i < 10; i++) rand_cmd(1);
        @(negedge clk);
        cmd_op[1] = 8'h01; cmd_rd[1] = 3'd1; cmd_rs[1] = 3'd0; cmd_imm_en[1] = 1'b1;
        cmd_imm[1] = 8'h55; cmd_valid[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid[1] = 1'b0;
        chk("l3_issue1_sel", alu_sel[1], 8'h01);
        @(posedge clk);
        @(negedge clk);
        chk("l3_issue2_sel", alu_sel[1], 8'h01);
        rst_n[1] = 1'b0;
        mdl_reset(1);
        #1;
        reset_check(1);
        @(negedge clk);
        rst_n[1] = 1'b1;
        @(negedge clk);
        dbg_sweep(1, "after_abort");
        do_cmd(1, 8'h01, 3, 0, 0, 1'b1, 8'h21, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
